// File: rtl/debounce_edge_detect.sv
`default_nettype none
// ============================================================================
//  Module      : debounce_edge_detect
//  Description : Conditions a raw asynchronous 1-bit input. A multi-flop
//                synchronizer feeds a four-state debounce FSM. The FSM drives
//                a registered level plus one-cycle rise/fall pulses. A
//                saturating counter tracks accepted rising edges.
//  Revision    : 1.0 - initial release
// ============================================================================
module debounce_edge_detect #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             d_in,
    input  logic             clr_cnt,
    output logic             level,
    output logic             rise,
    output logic             fall,
    output logic [CNT_W-1:0] edge_cnt,
    output logic             cnt_sat
);

    // Debounce counter only needs to reach STABLE_CYCLES-1.
    localparam int DB_W = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;

    localparam logic [DB_W-1:0]  c_db_last = DB_W'(STABLE_CYCLES - 1);
    localparam logic [DB_W-1:0]  c_db_one  = DB_W'(1);
    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

    localparam logic [1:0] c_st_low       = 2'd0;
    localparam logic [1:0] c_st_wait_high = 2'd1;
    localparam logic [1:0] c_st_high      = 2'd2;
    localparam logic [1:0] c_st_wait_low  = 2'd3;

    logic [SYNC_STAGES-1:0] r_sync;
    logic [1:0]             r_state;
    logic [DB_W-1:0]        r_db;
    logic                   r_level;
    logic                   r_rise;
    logic                   r_fall;
    logic [CNT_W-1:0]       r_edge_cnt;
    logic                   w_d_sync;
    logic                   w_rise_set;

    assign w_d_sync = r_sync[SYNC_STAGES-1];

    // The edge at which the FSM accepts a rise; the counter sees it on the same edge.
    assign w_rise_set = (r_state == c_st_wait_high) && w_d_sync && (r_db == c_db_last);

    // Synchronizer chain: bring d_in into the clk domain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], d_in};
        end
    end

    // Debounce FSM with registered level and single-cycle edge pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_st_low;
            r_db    <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            case (r_state)
                c_st_low: begin
                    if (w_d_sync) begin
                        r_state <= c_st_wait_high;
                        r_db    <= c_db_one;
                    end
                end
                c_st_wait_high: begin
                    if (!w_d_sync) begin
                        r_state <= c_st_low;
                        r_db    <= '0;
                    end else if (r_db == c_db_last) begin
                        r_state <= c_st_high;
                        r_level <= 1'b1;
                        r_rise  <= 1'b1;
                    end else begin
                        r_db <= r_db + c_db_one;
                    end
                end
                c_st_high: begin
                    if (!w_d_sync) begin
                        r_state <= c_st_wait_low;
                        r_db    <= c_db_one;
                    end
                end
                c_st_wait_low: begin
                    if (w_d_sync) begin
                        r_state <= c_st_high;
                        r_db    <= '0;
                    end else if (r_db == c_db_last) begin
                        r_state <= c_st_low;
                        r_level <= 1'b0;
                        r_fall  <= 1'b1;
                    end else begin
                        r_db <= r_db + c_db_one;
                    end
                end
                default: begin
                    r_state <= c_st_low;
                    r_db    <= '0;
                    r_level <= 1'b0;
                end
            endcase
        end
    end

    // Saturating rise counter; a clear beats a simultaneous rise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_edge_cnt <= '0;
        end else if (clr_cnt) begin
            r_edge_cnt <= '0;
        end else if (w_rise_set && (r_edge_cnt != c_cnt_max)) begin
            r_edge_cnt <= r_edge_cnt + CNT_W'(1);
        end
    end

    assign level    = r_level;
    assign rise     = r_rise;
    assign fall     = r_fall;
    assign edge_cnt = r_edge_cnt;
    assign cnt_sat  = (r_edge_cnt == c_cnt_max);

endmodule
`default_nettype wire

// File: tb/tb_debounce_edge_detect.sv
`default_nettype none
// ============================================================================
//  Module      : tb_debounce_edge_detect
//  Description : Directed bench for debounce_edge_detect. Expected pulses are
//                queued as stimulus is driven and matched by a monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_debounce_edge_detect;

    localparam int SYNC_STAGES   = 2;
    localparam int STABLE_CYCLES = 4;
    localparam int CNT_W         = 2;
    // Edges from the first sampling edge to the output update (6 edges counting it).
    localparam int LAT           = SYNC_STAGES + STABLE_CYCLES - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             d_in;
    logic             clr_cnt;
    logic             level;
    logic             rise;
    logic             fall;
    logic [CNT_W-1:0] edge_cnt;
    logic             cnt_sat;

    typedef struct {
        logic is_rise;
        logic exp_level;
        int   exp_cnt;
    } ev_t;

    ev_t sb[$];
    int  n_checks = 0;
    int  n_errors = 0;

    debounce_edge_detect #(
        .SYNC_STAGES  (SYNC_STAGES),
        .STABLE_CYCLES(STABLE_CYCLES),
        .CNT_W        (CNT_W)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .d_in    (d_in),
        .clr_cnt (clr_cnt),
        .level   (level),
        .rise    (rise),
        .fall    (fall),
        .edge_cnt(edge_cnt),
        .cnt_sat (cnt_sat)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor: every pulse must match the next queued expectation.
    always @(negedge clk) begin
        ev_t ev;
        if (!reset && (rise || fall)) begin
            if (sb.size() == 0) begin
                chk("unexpected_pulse", {30'b0, rise, fall}, 32'd0);
            end else begin
                ev = sb.pop_front();
                chk("pulse_kind", {30'b0, rise, fall}, ev.is_rise ? 32'd2 : 32'd1);
                chk("pulse_level", level, ev.exp_level);
                chk("pulse_cnt", edge_cnt, ev.exp_cnt);
                chk("pulse_sat", cnt_sat, (ev.exp_cnt == 3) ? 32'd1 : 32'd0);
            end
        end
    end

    // Drive a clean held change and check level/pulse timing around it.
    task automatic edge_step(input logic val, input int exp_cnt, input string tag);
        ev_t ev;
        d_in = val;
        ev.is_rise   = val;
        ev.exp_level = val;
        ev.exp_cnt   = exp_cnt;
        sb.push_back(ev);
        repeat (LAT) begin
            @(negedge clk);
            chk({tag, "_level_hold"}, level, !val);
        end
        @(negedge clk);
        chk({tag, "_level_new"}, level, val);
        chk({tag, "_pulse_on"}, val ? rise : fall, 1);
        chk({tag, "_other_off"}, val ? fall : rise, 0);
        @(negedge clk);
        chk({tag, "_pulse_off"}, {rise, fall}, 0);
        chk({tag, "_cnt"}, edge_cnt, exp_cnt);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        ev_t ev;
        reset   = 1'b0;
        d_in    = 1'b1;
        clr_cnt = 1'b0;
        #2 reset = 1'b1;

        // Reset held with d_in high: everything stays zero.
        repeat (4) begin
            @(negedge clk);
            chk("reset_outputs", {level, rise, fall, cnt_sat, edge_cnt}, 0);
        end

        // Release with d_in still high: a normal rise after full latency.
        reset = 1'b0;
        edge_step(1'b1, 1, "t1_rise");

        // Falling edge from level=1.
        edge_step(1'b0, 1, "t4_fall");

        // Three-cycle glitch is rejected.
        d_in = 1'b1;
        repeat (3) @(negedge clk);
        d_in = 1'b0;
        repeat (12) begin
            @(negedge clk);
            chk("t2_level_low", level, 0);
        end
        chk("t2_cnt", edge_cnt, 1);

        // Sub-cycle pulses between edges are invisible.
        repeat (8) begin
            @(negedge clk);
            #3 d_in = 1'b1;
            #3 d_in = 1'b0;
        end
        repeat (10) @(negedge clk);
        chk("t3_level_low", level, 0);
        chk("t3_cnt", edge_cnt, 1);

        // Clear, then five clean pulses saturate the 2-bit counter.
        clr_cnt = 1'b1;
        @(negedge clk);
        clr_cnt = 1'b0;
        chk("t5_clear", edge_cnt, 0);
        chk("t5_clear_sat", cnt_sat, 0);
        for (int i = 1; i <= 5; i++) begin
            edge_step(1'b1, (i > 3) ? 3 : i, "t5_rise");
            edge_step(1'b0, (i > 3) ? 3 : i, "t5_fall");
        end
        chk("t5_sat_cnt", edge_cnt, 3);
        chk("t5_sat_flag", cnt_sat, 1);

        // Clear on the very edge that accepts a rise: the rise is not counted.
        d_in = 1'b1;
        ev.is_rise   = 1'b1;
        ev.exp_level = 1'b1;
        ev.exp_cnt   = 0;
        sb.push_back(ev);
        repeat (LAT) @(negedge clk);
        clr_cnt = 1'b1;
        @(negedge clk);
        clr_cnt = 1'b0;
        chk("t5_clr_rise_pulse", rise, 1);
        chk("t5_clr_rise_cnt", edge_cnt, 0);
        @(negedge clk);
        chk("t5_clr_after_cnt", edge_cnt, 0);
        chk("t5_clr_after_sat", cnt_sat, 0);
        repeat (2) @(negedge clk);
        edge_step(1'b0, 0, "t5_clr_fall");

        // Bring the counter to 1, then reset asynchronously mid-wait.
        edge_step(1'b1, 1, "t6_rise");
        edge_step(1'b0, 1, "t6_fall");
        d_in = 1'b1;
        repeat (3) @(negedge clk);
        chk("t6_pre_cnt", edge_cnt, 1);
        #3 reset = 1'b1;
        d_in = 1'b0;
        #1 chk("t6_async_reset", {level, rise, fall, cnt_sat, edge_cnt}, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (15) @(negedge clk);
        chk("t6_level_low", level, 0);
        chk("t6_cnt", edge_cnt, 0);

        chk("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
